// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder sequencer driving a gate-level full adder
//
// Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first,
// using a single fulladder cell. Handshake is start/busy/done.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only in IDLE
//   a, b   operands, captured on accepted start
//   cin    carry-in, captured on accepted start
//   busy   high while the addition is running
//   done   one-cycle pulse when sum/cout have just been updated
//   sum    registered sum, held until the next completion
//   cout   registered carry-out, held until the next completion
//   ovf    signed overflow flag, present only with SERIAL_ADDER_OVF_EN defined
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf output.

module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic p, g, t;
   xor x0 (p, a, b);
   xor x1 (sum, p, cin);
   and a0 (g, a, b);
   and a1 (t, p, cin);
   or  o0 (cout, g, t);
endmodule

module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic            ovf
`endif
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] sa, sb, acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fs, fc;
   fulladder u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (carry),
      .sum  (fs),
      .cout (fc)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         sa    <= '0;
         sb    <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               carry <= fc;
               acc   <= {fs, acc[WIDTH-1:1]};
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  sum   <= {fs, acc[WIDTH-1:1]};
                  cout  <= fc;
`ifdef SERIAL_ADDER_OVF_EN
                  // on the last bit the carry flop holds the carry into the MSB
                  ovf   <= carry ^ fc;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: scoreboard bench for serial_adder_seq against an arithmetic model
module tb_serial_adder_seq;
   localparam int W = 8;
   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif
   serial_adder_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,.ovf  (ovf)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;
   exp_t q[$];
   exp_t me;
   int tests = 0, fails = 0, dones = 0;
   task automatic check(string n, logic [63:0] act, logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, expv);
      end
   endtask
   function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci);
      exp_t   m;
      longint u, sv, lim;
      u     = longint'(x) + longint'(y) + longint'(ci);
      sv    = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      lim   = longint'(1) << (W - 1);
      m.s   = u[W-1:0];
      m.c   = u[W];
      m.o   = (sv > lim - 1) || (sv < -lim);
      return m;
   endfunction
   always @(negedge clk) begin
      if (done) begin
         dones++;
         if (q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
         else begin
            me = q.pop_front();
            check("sum", 64'(sum), 64'(me.s));
            check("cout", 64'(cout), 64'(me.c));
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", 64'(ovf), 64'(me.o));
`endif
         end
      end
   end
   task automatic run(logic [W-1:0] x, logic [W-1:0] y, logic ci, bit inject);
      logic [W-1:0] prev;
      int           nb;
      @(negedge clk);
      for (int i = 0; i < 4 * W && (busy || done); i++) @(negedge clk);
      a = x; b = y; cin = ci; start = 1'b1;
      q.push_back(model(x, y, ci));
      prev = sum;
      nb = 0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W + 5 && !done; i++) begin
         if (busy) nb++;
         if (i == 1) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (inject) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
         end
         if (i == 2) start = 1'b0;
         if (i == W / 2) check("sum_held", 64'(sum), 64'(prev));
         @(negedge clk);
      end
      check("done_seen", 64'(done), 64'd1);
      check("busy_cycles", 64'(nb), 64'(W));
      @(negedge clk);
      check("done_pulse_one", 64'(done), 64'd0);
   endtask
   initial begin
      int d0;
      #1;
      check("rst_async", {busy, done, cout, sum}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle", {busy, done, cout, sum}, 64'd0);
      end
      run(8'h35, 8'h4A, 1'b0, 1'b0);
      run(8'hFF, 8'h00, 1'b1, 1'b0);
      run(8'h7F, 8'h01, 1'b0, 1'b0);
      d0 = dones;
      run(8'h10, 8'h20, 1'b0, 1'b1);
      repeat (W + 4) @(negedge clk);
      check("one_done_on_ignored_start", 64'(dones - d0), 64'd1);
      for (int k = 0; k < 20; k++) run(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      run(8'hFF, 8'hFF, 1'b1, 1'b0);
      d0 = dones;
      @(negedge clk);
      a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_sum", 64'(sum), 64'd0);
      check("abort_cout", 64'(cout), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 4) @(negedge clk);
      check("abort_no_done", 64'(dones - d0), 64'd0);
      run(8'h01, 8'h01, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("queue_empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
